// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT ping-pong buffer controller.
// Holds the bank state encoding, the status bit map and the signed bit-width function.
package fft_pkg;

  typedef enum logic [2:0] {
    B_FREE,
    B_FILL,
    B_FULL,
    B_BUSY,
    B_RESULT
  } bank_state_t;

  localparam int ST_IN_READY  = 0;
  localparam int ST_BUSY      = 1;
  localparam int ST_RES_VALID = 2;

  // Smallest k with -2^k <= x < 2^k. Negative values are folded onto ~x,
  // so the result is the index of the highest set bit plus one.
  function automatic logic [5:0] sbw(input logic signed [31:0] x);
    logic [31:0] m;
    logic [5:0]  k;
    m = x[31] ? ~x : x;
    k = '0;
    for (int i = 0; i < 32; i++)
      if (m[i]) k = 6'(i + 1);
    return k;
  endfunction

endpackage

// File: rtl/fft_bitrev_iter.sv
// Frame sample counter that also presents its value bit-reversed for
// FFT input ordering. o_full flags the last index of the frame.
module fft_bitrev_iter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [N-1:0] o_cnt,
  output logic [N-1:0] o_addr,
  output logic         o_full
);

  logic [N-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  always_comb begin
    o_addr = '0;
    for (int i = 0; i < N; i++)
      o_addr[i] = r_cnt[N-1-i];
  end

  assign o_cnt  = r_cnt;
  assign o_full = &r_cnt;

endmodule

// File: rtl/fft_pingpong_ctrl.sv
// Two-bank ping-pong controller: fills one bank with bit-reversed samples while
// the FFT engine works on the other and the host drains results.
module fft_pingpong_ctrl
  import fft_pkg::*;
#(
  parameter int FFT_LENGTH = 1024,
  parameter int FFT_DW     = 16,
  parameter int FFT_N      = $clog2(FFT_LENGTH),
  parameter int MAXBW_W    = $clog2(FFT_DW) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     autorun,
  input  logic                     run,
  input  logic                     fin,
  input  logic                     in_valid,
  input  logic signed [FFT_DW-1:0] in_real,
  input  logic signed [FFT_DW-1:0] in_imag,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic                     wr_bank,
  output logic [FFT_N-1:0]         wr_addr,
  output logic [2*FFT_DW-1:0]      wr_data,
  output logic                     fft_start,
  output logic                     fft_bank,
  output logic [MAXBW_W-1:0]       fft_bw,
  input  logic                     fft_done,
  output logic                     res_valid,
  output logic                     res_bank,
  output logic [MAXBW_W-1:0]       res_bw,
  output logic [2:0]               status,
  output logic [15:0]              ovf_count
);

  bank_state_t r_st [2];
  logic [MAXBW_W-1:0] r_bw [2];
  logic r_fb, r_cb, r_rb;
  logic r_wr_en, r_wr_bank, r_fft_start, r_fft_bank;
  logic [FFT_N-1:0] r_wr_addr;
  logic [2*FFT_DW-1:0] r_wr_data;
  logic [MAXBW_W-1:0] r_fft_bw;
  logic [15:0] r_ovf;

  logic w_in_ready, w_acc, w_last, w_any_busy, w_start, w_res_valid, w_full;
  logic [FFT_N-1:0] w_cnt, w_addr;
  logic [MAXBW_W-1:0] w_bw_re, w_bw_im, w_sw;

  assign w_in_ready  = (r_st[r_fb] == B_FREE) || (r_st[r_fb] == B_FILL);
  assign w_acc       = in_valid && w_in_ready;
  assign w_last      = w_acc && w_full;
  assign w_any_busy  = (r_st[0] == B_BUSY) || (r_st[1] == B_BUSY);
  // Bank state is registered, so a bank that goes FULL this edge starts next cycle at the earliest.
  assign w_start     = (r_st[r_cb] == B_FULL) && !w_any_busy && (autorun || run);
  assign w_res_valid = (r_st[r_rb] == B_RESULT);

  assign w_bw_re = MAXBW_W'(sbw(32'(in_real)));
  assign w_bw_im = MAXBW_W'(sbw(32'(in_imag)));
  assign w_sw    = (w_bw_re > w_bw_im) ? w_bw_re : w_bw_im;

  fft_bitrev_iter #(.N(FFT_N)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_last),
    .i_inc  (w_acc),
    .o_cnt  (w_cnt),
    .o_addr (w_addr),
    .o_full (w_full)
  );

  // Fill, start, done and fin each target a bank in a distinct state, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st[0]     <= B_FREE;
      r_st[1]     <= B_FREE;
      r_bw[0]     <= '0;
      r_bw[1]     <= '0;
      r_fb        <= 1'b0;
      r_cb        <= 1'b0;
      r_rb        <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_fft_start <= 1'b0;
      r_fft_bank  <= 1'b0;
      r_fft_bw    <= '0;
      r_ovf       <= '0;
    end else begin
      if (w_acc) begin
        r_st[r_fb] <= w_last ? B_FULL : B_FILL;
        if (w_cnt == '0 || w_sw > r_bw[r_fb])
          r_bw[r_fb] <= w_sw;
        if (w_last)
          r_fb <= ~r_fb;
        r_wr_bank <= r_fb;
        r_wr_addr <= w_addr;
        r_wr_data <= {in_imag, in_real};
      end
      r_wr_en <= w_acc;
      if (w_start) begin
        r_st[r_cb] <= B_BUSY;
        r_fft_bank <= r_cb;
        r_fft_bw   <= r_bw[r_cb];
      end
      r_fft_start <= w_start;
      if (fft_done && w_any_busy) begin
        r_st[r_cb] <= B_RESULT;
        r_cb       <= ~r_cb;
      end
      if (fin && w_res_valid) begin
        r_st[r_rb] <= B_FREE;
        r_rb       <= ~r_rb;
      end
      if (in_valid && !w_in_ready && r_ovf != 16'hFFFF)
        r_ovf <= r_ovf + 16'd1;
    end
  end

  assign in_ready  = w_in_ready;
  assign wr_en     = r_wr_en;
  assign wr_bank   = r_wr_bank;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign fft_start = r_fft_start;
  assign fft_bank  = r_fft_bank;
  assign fft_bw    = r_fft_bw;
  assign res_valid = w_res_valid;
  assign res_bank  = r_rb;
  assign res_bw    = r_bw[r_rb];
  assign ovf_count = r_ovf;

  always_comb begin
    status               = '0;
    status[ST_IN_READY]  = w_in_ready;
    status[ST_BUSY]      = w_any_busy;
    status[ST_RES_VALID] = w_res_valid;
  end

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// Directed bench for fft_pingpong_ctrl with an 8-point frame: ordering, widths,
// start gating, overflow, simultaneous fin/done and asynchronous reset.
module tb_fft_pingpong_ctrl;

  logic clk = 1'b0;
  logic reset, autorun, run, fin, in_valid, fft_done;
  logic signed [15:0] in_real, in_imag;
  logic in_ready, wr_en, wr_bank, fft_start, fft_bank, res_valid, res_bank;
  logic [2:0] wr_addr;
  logic [31:0] wr_data;
  logic [4:0] fft_bw, res_bw;
  logic [2:0] status;
  logic [15:0] ovf_count;

  int n_cmp = 0;
  int n_err = 0;

  fft_pingpong_ctrl #(.FFT_LENGTH(8), .FFT_DW(16)) dut (
    .clk(clk), .reset(reset), .autorun(autorun), .run(run), .fin(fin),
    .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag), .in_ready(in_ready),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .fft_start(fft_start), .fft_bank(fft_bank), .fft_bw(fft_bw), .fft_done(fft_done),
    .res_valid(res_valid), .res_bank(res_bank), .res_bw(res_bw),
    .status(status), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int exp_addr [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic signed [15:0] ra [8] = '{16'sd100, -16'sd1, 16'sd5, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd3};
    logic signed [15:0] ia [8] = '{-16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd64};

    reset = 1'b1; autorun = 1'b0; run = 1'b0; fin = 1'b0;
    in_valid = 1'b0; in_real = '0; in_imag = '0; fft_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_fft_start", 32'(fft_start), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_ovf", 32'(ovf_count), 0);
    chk("rst_status", 32'(status), 32'b001);

    // Frame 1: bank 0, autorun, widths 100 / -1 / 64 -> 7
    autorun = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(ra[i], ia[i]);
      chk("a_wr_en", 32'(wr_en), 1);
      chk("a_wr_bank", 32'(wr_bank), 0);
      chk("a_wr_addr", 32'(wr_addr), 32'(exp_addr[i]));
      if (i == 0) chk("a_wr_data", wr_data, 32'hFFFF0064);
    end
    chk("a_no_early_start", 32'(fft_start), 0);
    tick();
    chk("a_fft_start", 32'(fft_start), 1);
    chk("a_fft_bank", 32'(fft_bank), 0);
    chk("a_fft_bw", 32'(fft_bw), 7);
    chk("a_status_busy", 32'(status), 32'b011);
    tick();
    chk("a_start_pulse", 32'(fft_start), 0);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk("a_res_valid", 32'(res_valid), 1);
    chk("a_res_bank", 32'(res_bank), 0);
    chk("a_res_bw", 32'(res_bw), 7);
    fin = 1'b1; tick(); fin = 1'b0;
    chk("a_fin", 32'(res_valid), 0);

    // Frame 2: bank 1, single -32768 -> width 15
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? -16'sd32768 : 16'sd0, 16'sd0);
      if (i == 0) chk("b_wr_bank", 32'(wr_bank), 1);
    end
    tick();
    chk("b_fft_start", 32'(fft_start), 1);
    chk("b_fft_bank", 32'(fft_bank), 1);
    chk("b_fft_bw", 32'(fft_bw), 15);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk("b_res_bank", 32'(res_bank), 1);
    fin = 1'b1; tick(); fin = 1'b0;

    // Frame 3: bank 0, zeros, manual run
    autorun = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run = (i == 3);
      send(16'sd0, 16'sd0);
    end
    run = 1'b0;
    tick();
    chk("c_run_ignored", 32'(fft_start), 0);
    tick();
    chk("c_no_start", 32'(fft_start), 0);
    run = 1'b1; tick(); run = 1'b0;
    chk("c_fft_start", 32'(fft_start), 1);
    chk("c_fft_bank", 32'(fft_bank), 0);
    chk("c_fft_bw", 32'(fft_bw), 0);

    // Frame 4: bank 1 fills while bank 0 busy, then overflow
    for (int i = 0; i < 8; i++) send(16'(i), 16'sd0);
    chk("d_not_ready", 32'(in_ready), 0);
    chk("d_no_start", 32'(fft_start), 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_drop_wr_en", 32'(wr_en), 0);
    end
    in_valid = 1'b0;
    chk("d_ovf", 32'(ovf_count), 3);
    autorun = 1'b1;
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk("d_res_valid", 32'(res_valid), 1);
    chk("d_res_bank", 32'(res_bank), 0);
    tick();
    chk("d_fft_start", 32'(fft_start), 1);
    chk("d_fft_bank", 32'(fft_bank), 1);
    fin = 1'b1; fft_done = 1'b1; tick(); fin = 1'b0; fft_done = 1'b0;
    chk("e_res_valid", 32'(res_valid), 1);
    chk("e_res_bank", 32'(res_bank), 1);
    chk("e_status", 32'(status), 32'b101);
    fin = 1'b1; tick(); fin = 1'b0;

    // Frame 5 on bank 0 goes busy, partial frame on bank 1, then reset
    for (int i = 0; i < 8; i++) send(16'sd1, 16'sd1);
    tick();
    chk("f_fft_start", 32'(fft_start), 1);
    send(16'sd2, 16'sd0);
    send(16'sd2, 16'sd0);
    in_valid = 1'b1; in_real = 16'sd2;
    tick();
    chk("f_wr_en_pre", 32'(wr_en), 1);
    chk("f_status_pre", 32'(status), 32'b011);
    #2 reset = 1'b1;
    #1;
    chk("f_rst_wr_en", 32'(wr_en), 0);
    chk("f_rst_status", 32'(status), 32'b001);
    chk("f_rst_ovf", 32'(ovf_count), 0);
    chk("f_rst_res_valid", 32'(res_valid), 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    send(16'sd7, 16'sd0);
    chk("g_wr_en", 32'(wr_en), 1);
    chk("g_wr_bank", 32'(wr_bank), 0);
    chk("g_wr_addr0", 32'(wr_addr), 0);
    send(16'sd7, 16'sd0);
    chk("g_wr_addr1", 32'(wr_addr), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
